isqrt_odd: RTL

ISQRT_ODD -- requirements
Module: isqrt_odd

---
 rtl/psd_pkg.sv | 12 +
 rtl/isqrt_odd_if.sv | 26 ++
 rtl/isqrt_odd.sv | 106 ++++++++++
 3 files changed

// File: rtl/psd_pkg.sv
// Shared FSM encoding and default root width for the isqrt_odd block.
package psd_pkg;

  localparam int unsigned PSD_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } isqrt_state_e;

endpackage

// File: rtl/isqrt_odd_if.sv
// Valid/ready request and result channels of isqrt_odd; master is the requester side.
interface isqrt_odd_if
  import psd_pkg::*;
#(
  parameter int unsigned DATA_W = PSD_DATA_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [2*DATA_W-1:0]   in_pow;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_root;
  logic [DATA_W:0]       out_rem;

  modport master (
    output in_valid, in_pow, out_ready,
    input  in_ready, out_valid, out_root, out_rem
  );

  modport slave (
    input  in_valid, in_pow, out_ready,
    output in_ready, out_valid, out_root, out_rem
  );

endinterface

// File: rtl/isqrt_odd.sv
// Integer square root by subtracting successive odd numbers, one per clock.
// Define ISQRT_ODD_ROUND_EN for a round-to-nearest root (saturating); default is floor.
module isqrt_odd
  import psd_pkg::*;
#(
  parameter int unsigned DATA_W = PSD_DATA_W
) (
  input logic        clk,
  input logic        rst,
  isqrt_odd_if.slave bus
);

  localparam int unsigned PowW = 2 * DATA_W;
  localparam int unsigned OddW = DATA_W + 2;

  isqrt_state_e      r_state, w_state_next;
  logic [PowW-1:0]   r_rem, w_rem_next;
  logic [OddW-1:0]   r_odd, w_odd_next;
  logic [DATA_W-1:0] r_cnt, w_cnt_next;
  logic              r_out_valid, w_out_valid_next;
  logic [DATA_W-1:0] r_out_root, w_out_root_next;
  logic [DATA_W:0]   r_out_rem, w_out_rem_next;

  logic              w_fits;
  logic [DATA_W-1:0] w_root_final;

  assign w_fits = r_rem >= PowW'(r_odd);

`ifdef ISQRT_ODD_ROUND_EN
  // Floor remainder above the floor root means sqrt lies past root + 0.5.
  logic w_round_up;
  assign w_round_up   = (r_rem > PowW'(r_cnt)) && (r_cnt != '1);
  assign w_root_final = r_cnt + DATA_W'(w_round_up);
`else
  assign w_root_final = r_cnt;
`endif

  assign bus.in_ready  = (r_state == StIdle) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_root  = r_out_root;
  assign bus.out_rem   = r_out_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rem       <= '0;
      r_odd       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_root  <= '0;
      r_out_rem   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rem       <= w_rem_next;
      r_odd       <= w_odd_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_out_root  <= w_out_root_next;
      r_out_rem   <= w_out_rem_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rem_next       = r_rem;
    w_odd_next       = r_odd;
    w_cnt_next       = r_cnt;
    w_out_valid_next = r_out_valid;
    w_out_root_next  = r_out_root;
    w_out_rem_next   = r_out_rem;

    case (r_state)
      StIdle: begin
        if (bus.in_valid) begin
          w_rem_next   = bus.in_pow;
          w_odd_next   = OddW'(1);
          w_cnt_next   = '0;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_fits) begin
          w_rem_next = r_rem - PowW'(r_odd);
          w_odd_next = r_odd + OddW'(2);
          w_cnt_next = r_cnt + DATA_W'(1);
        end else begin
          // Floor remainder is at most 2*root, so it fits DATA_W+1 bits.
          w_out_root_next  = w_root_final;
          w_out_rem_next   = r_rem[DATA_W:0];
          w_out_valid_next = 1'b1;
          w_state_next     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_out_valid_next = 1'b0;
          w_state_next     = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

endmodule
